// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory arbiter: default widths and port ids.
package imem_pkg;

  localparam int unsigned IMEM_DEPTH_LOG2_DEF = 10;
  localparam int unsigned XLEN_DEF            = 32;

  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_DBG   = 1'b1
  } port_id_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; bit 0 is fetch, bit 1 is debug. Grant is combinational,
// the last-granted pointer advances only when a grant is issued.
module rr_arb2
  import imem_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_c_o
);

  port_id_e last_q, last_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= PORT_DBG;
    end else begin
      last_q <= last_d;
    end
  end

  // On conflict, favour the port that was not granted most recently.
  always_comb begin
    gnt_c_o = 2'b00;
    if (req_i == 2'b11) begin
      if (last_q == PORT_FETCH) begin
        gnt_c_o = 2'b10;
      end else begin
        gnt_c_o = 2'b01;
      end
    end else begin
      gnt_c_o = req_i;
    end
  end

  always_comb begin
    last_d = last_q;
    if (gnt_c_o[0]) begin
      last_d = PORT_FETCH;
    end else if (gnt_c_o[1]) begin
      last_d = PORT_DBG;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Shares one single-port instruction memory between the fetch unit and the debug/loader port,
// with one-cycle registered responses and address-range checking.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH_LOG2 = IMEM_DEPTH_LOG2_DEF,
  parameter int unsigned XLEN            = XLEN_DEF
) (
  input  logic                       clk,
  input  logic                       reset_n,

  input  logic                       io_fetch_req_valid,
  output logic                       io_fetch_req_ready,
  input  logic [XLEN-1:0]            io_fetch_req_addr,
  input  logic                       io_fetch_flush,
  output logic                       io_fetch_resp_valid,
  output logic [XLEN-1:0]            io_fetch_resp_data,
  output logic                       io_fetch_resp_err,

  input  logic                       io_dbg_req_valid,
  output logic                       io_dbg_req_ready,
  input  logic [XLEN-1:0]            io_dbg_req_addr,
  input  logic                       io_dbg_req_wr,
  input  logic [XLEN-1:0]            io_dbg_req_wdata,
  output logic                       io_dbg_resp_valid,
  output logic [XLEN-1:0]            io_dbg_resp_data,
  output logic                       io_dbg_resp_err,

  output logic [IMEM_DEPTH_LOG2-1:0] io_mem_addr,
  input  logic [XLEN-1:0]            io_mem_rdata,
  output logic                       io_mem_wen,
  output logic [XLEN-1:0]            io_mem_wdata
);

  localparam int unsigned IDX_LSB = 2;
  localparam int unsigned IDX_MSB = IMEM_DEPTH_LOG2 + 1;

  // Misaligned, or addressing beyond the end of the memory.
  function automatic logic addr_bad(input logic [XLEN-1:0] a);
    return (a[1:0] != 2'b00) || ((a >> (IDX_MSB + 1)) != '0);
  endfunction

  logic [1:0]      gnt_c;
  logic            fetch_acc_c;
  logic            dbg_acc_c;
  logic [XLEN-1:0] sel_addr_c;
  logic            sel_bad_c;

  logic            fetch_vld_q, fetch_vld_d;
  logic            fetch_err_q, fetch_err_d;
  logic [XLEN-1:0] fetch_data_q, fetch_data_d;
  logic            dbg_vld_q, dbg_vld_d;
  logic            dbg_err_q, dbg_err_d;
  logic [XLEN-1:0] dbg_data_q, dbg_data_d;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .reset_n (reset_n),
    .req_i   ({io_dbg_req_valid, io_fetch_req_valid}),
    .gnt_c_o (gnt_c)
  );

  // Nothing is granted while reset is held.
  assign fetch_acc_c = reset_n & gnt_c[0];
  assign dbg_acc_c   = reset_n & gnt_c[1];

  assign io_fetch_req_ready = fetch_acc_c;
  assign io_dbg_req_ready   = dbg_acc_c;

  assign sel_addr_c = dbg_acc_c ? io_dbg_req_addr : io_fetch_req_addr;
  assign sel_bad_c  = addr_bad(sel_addr_c);

  assign io_mem_addr  = (fetch_acc_c | dbg_acc_c) ? sel_addr_c[IDX_MSB:IDX_LSB] : '0;
  assign io_mem_wen   = dbg_acc_c & io_dbg_req_wr & ~sel_bad_c;
  assign io_mem_wdata = io_mem_wen ? io_dbg_req_wdata : '0;

  always_comb begin
    fetch_vld_d  = 1'b0;
    fetch_err_d  = 1'b0;
    fetch_data_d = '0;
    dbg_vld_d    = 1'b0;
    dbg_err_d    = 1'b0;
    dbg_data_d   = '0;
    if (fetch_acc_c) begin
      fetch_vld_d  = 1'b1;
      fetch_err_d  = sel_bad_c;
      fetch_data_d = sel_bad_c ? '0 : io_mem_rdata;
    end
    if (dbg_acc_c) begin
      dbg_vld_d  = 1'b1;
      dbg_err_d  = sel_bad_c;
      dbg_data_d = (sel_bad_c || io_dbg_req_wr) ? '0 : io_mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_vld_q  <= 1'b0;
      fetch_err_q  <= 1'b0;
      fetch_data_q <= '0;
      dbg_vld_q    <= 1'b0;
      dbg_err_q    <= 1'b0;
      dbg_data_q   <= '0;
    end else begin
      fetch_vld_q  <= fetch_vld_d;
      fetch_err_q  <= fetch_err_d;
      fetch_data_q <= fetch_data_d;
      dbg_vld_q    <= dbg_vld_d;
      dbg_err_q    <= dbg_err_d;
      dbg_data_q   <= dbg_data_d;
    end
  end

  // A flush suppresses the fetch response landing in the same cycle.
  assign io_fetch_resp_valid = fetch_vld_q & ~io_fetch_flush;
  assign io_fetch_resp_data  = io_fetch_resp_valid ? fetch_data_q : '0;
  assign io_fetch_resp_err   = io_fetch_resp_valid & fetch_err_q;

  assign io_dbg_resp_valid = dbg_vld_q;
  assign io_dbg_resp_data  = dbg_vld_q ? dbg_data_q : '0;
  assign io_dbg_resp_err   = dbg_vld_q & dbg_err_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: per-cycle vector table plus reset corner sequences.
module tb_imem_arbiter;

  logic        clk;
  logic        reset_n;
  logic        fv, fl, dv, dwr;
  logic [31:0] fa, da, dwd;
  logic        frdy, frv, fre, drdy, drv, dre, wen;
  logic [31:0] frd, drd, rdata, wdata;
  logic [9:0]  maddr;

  logic [31:0] mem [1024];

  typedef struct packed {
    logic        frdy;
    logic        drdy;
    logic        wen;
    logic [9:0]  maddr;
    logic [31:0] wdata;
    logic        frv;
    logic [31:0] frd;
    logic        fre;
    logic        drv;
    logic [31:0] drd;
    logic        dre;
  } obs_t;

  typedef struct packed {
    logic        fv;
    logic [31:0] fa;
    logic        fl;
    logic        dv;
    logic [31:0] da;
    logic        dwr;
    logic [31:0] dwd;
    obs_t        exp;
  } vec_t;

  int total = 0;
  int bad   = 0;

  imem_arbiter dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .io_fetch_req_valid  (fv),
    .io_fetch_req_ready  (frdy),
    .io_fetch_req_addr   (fa),
    .io_fetch_flush      (fl),
    .io_fetch_resp_valid (frv),
    .io_fetch_resp_data  (frd),
    .io_fetch_resp_err   (fre),
    .io_dbg_req_valid    (dv),
    .io_dbg_req_ready    (drdy),
    .io_dbg_req_addr     (da),
    .io_dbg_req_wr       (dwr),
    .io_dbg_req_wdata    (dwd),
    .io_dbg_resp_valid   (drv),
    .io_dbg_resp_data    (drd),
    .io_dbg_resp_err     (dre),
    .io_mem_addr         (maddr),
    .io_mem_rdata        (rdata),
    .io_mem_wen          (wen),
    .io_mem_wdata        (wdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign rdata = mem[maddr];

  always @(posedge clk) begin
    if (wen) mem[maddr] <= wdata;
  end

  function automatic obs_t observe();
    obs_t o;
    o.frdy = frdy; o.drdy = drdy; o.wen = wen; o.maddr = maddr; o.wdata = wdata;
    o.frv = frv; o.frd = frd; o.fre = fre; o.drv = drv; o.drd = drd; o.dre = dre;
    return o;
  endfunction

  function automatic vec_t mk(
    input logic f_v, input logic [31:0] f_a, input logic f_l,
    input logic d_v, input logic [31:0] d_a, input logic d_wr, input logic [31:0] d_wd,
    input logic e_frdy, input logic e_drdy, input logic e_wen, input logic [9:0] e_maddr,
    input logic [31:0] e_wdata,
    input logic e_frv, input logic [31:0] e_frd, input logic e_fre,
    input logic e_drv, input logic [31:0] e_drd, input logic e_dre);
    vec_t v;
    v.fv = f_v; v.fa = f_a; v.fl = f_l; v.dv = d_v; v.da = d_a; v.dwr = d_wr; v.dwd = d_wd;
    v.exp.frdy = e_frdy; v.exp.drdy = e_drdy; v.exp.wen = e_wen; v.exp.maddr = e_maddr;
    v.exp.wdata = e_wdata; v.exp.frv = e_frv; v.exp.frd = e_frd; v.exp.fre = e_fre;
    v.exp.drv = e_drv; v.exp.drd = e_drd; v.exp.dre = e_dre;
    return v;
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got frdy=%b drdy=%b wen=%b maddr=%0d wdata=%h frv=%b frd=%h fre=%b drv=%b drd=%h dre=%b",
               name, got.frdy, got.drdy, got.wen, got.maddr, got.wdata, got.frv, got.frd, got.fre,
               got.drv, got.drd, got.dre);
      $display("     %s: exp frdy=%b drdy=%b wen=%b maddr=%0d wdata=%h frv=%b frd=%h fre=%b drv=%b drd=%h dre=%b",
               name, exp.frdy, exp.drdy, exp.wen, exp.maddr, exp.wdata, exp.frv, exp.frd, exp.fre,
               exp.drv, exp.drd, exp.dre);
    end
  endtask

  task automatic drive(input vec_t v);
    fv = v.fv; fa = v.fa; fl = v.fl; dv = v.dv; da = v.da; dwr = v.dwr; dwd = v.dwd;
  endtask

  vec_t vecs [16];
  vec_t v;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    mem[4] = 32'hDEAD_BEEF;

    // Rows are one cycle each; response fields refer to the request of the previous row.
    vecs[0]  = mk(1, 32'h14, 0, 1, 32'h18, 0, 0,   1,0,0,10'd5,0,  0,0,0,                 0,0,0);
    vecs[1]  = mk(1, 32'h14, 0, 1, 32'h18, 0, 0,   0,1,0,10'd6,0,  1,32'hC0DE_0005,0,     0,0,0);
    vecs[2]  = mk(1, 32'h14, 0, 1, 32'h18, 0, 0,   1,0,0,10'd5,0,  0,0,0,                 1,32'hC0DE_0006,0);
    vecs[3]  = mk(1, 32'h14, 0, 1, 32'h18, 0, 0,   0,1,0,10'd6,0,  1,32'hC0DE_0005,0,     0,0,0);
    vecs[4]  = mk(1, 32'h10, 0, 0, 0, 0, 0,        1,0,0,10'd4,0,  0,0,0,                 1,32'hC0DE_0006,0);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0,             0,0,0,10'd0,0,  1,32'hDEAD_BEEF,0,     0,0,0);
    vecs[6]  = mk(0, 0, 0, 1, 32'h8, 1, 32'h1234_5678,
                                                   0,1,1,10'd2,32'h1234_5678, 0,0,0,      0,0,0);
    vecs[7]  = mk(1, 32'h8, 0, 0, 0, 0, 0,         1,0,0,10'd2,0,  0,0,0,                 1,0,0);
    vecs[8]  = mk(1, 32'h6, 0, 0, 0, 0, 0,         1,0,0,10'd1,0,  1,32'h1234_5678,0,     0,0,0);
    vecs[9]  = mk(1, 32'h1000, 0, 0, 0, 0, 0,      1,0,0,10'd0,0,  1,0,1,                 0,0,0);
    vecs[10] = mk(0, 0, 0, 1, 32'h3, 1, 32'hFFFF_FFFF,
                                                   0,1,0,10'd0,0,  1,0,1,                 0,0,0);
    vecs[11] = mk(1, 32'h0, 0, 0, 0, 0, 0,         1,0,0,10'd0,0,  0,0,0,                 1,0,1);
    vecs[12] = mk(1, 32'h10, 0, 0, 0, 0, 0,        1,0,0,10'd4,0,  1,32'hC0DE_0000,0,     0,0,0);
    vecs[13] = mk(1, 32'h14, 1, 0, 0, 0, 0,        1,0,0,10'd5,0,  0,0,0,                 0,0,0);
    vecs[14] = mk(0, 0, 0, 1, 32'h8000_0010, 0, 0, 0,1,0,10'd4,0,  1,32'hC0DE_0005,0,     0,0,0);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 0,             0,0,0,10'd0,0,  0,0,0,                 1,0,1);

    // Reset held with both ports requesting: nothing may be granted or written.
    reset_n = 1'b0;
    v = mk(1, 32'h14, 0, 1, 32'h18, 1, 32'h55, 0,0,0,10'd0,0, 0,0,0, 0,0,0);
    drive(v);
    @(negedge clk); #2;
    check("rst_hold", observe(), v.exp);

    @(negedge clk);
    reset_n = 1'b1;
    v = mk(0, 0, 0, 0, 0, 0, 0, 0,0,0,10'd0,0, 0,0,0, 0,0,0);
    drive(v);
    #2;
    check("rst_state", observe(), v.exp);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #2;
      check($sformatf("vec%0d", i), observe(), vecs[i].exp);
    end

    // Fetch accepted (pointer -> fetch), then reset before its response is seen.
    @(negedge clk);
    v = mk(1, 32'h10, 0, 0, 0, 0, 0, 1,0,0,10'd4,0, 0,0,0, 0,0,0);
    drive(v);
    #2;
    check("pre_rst_acc", observe(), v.exp);

    @(negedge clk);
    reset_n = 1'b0;
    v = mk(1, 32'h10, 0, 0, 0, 0, 0, 0,0,0,10'd0,0, 0,0,0, 0,0,0);
    drive(v);
    #2;
    check("rst_drop_resp", observe(), v.exp);

    @(negedge clk);
    reset_n = 1'b1;
    v = mk(1, 32'h14, 0, 1, 32'h18, 0, 0, 1,0,0,10'd5,0, 0,0,0, 0,0,0);
    drive(v);
    #2;
    check("post_rst_conflict", observe(), v.exp);

    @(negedge clk);
    v = mk(0, 0, 0, 0, 0, 0, 0, 0,0,0,10'd0,0, 1,32'hC0DE_0005,0, 0,0,0);
    drive(v);
    #2;
    check("post_rst_resp", observe(), v.exp);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter: IMEM_DEPTH_LOG2, default 10, word-index width of the shared instruction memory (1024 x 32).
REQ-002 Parameter: XLEN, default 32, address and data width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 io_fetch_req_valid  input  1  fetch read request.
REQ-006 io_fetch_req_ready  output  1  fetch request granted this cycle.
REQ-007 io_fetch_req_addr  input  XLEN  fetch byte address.
REQ-008 io_fetch_flush  input  1  discard the fetch response due this cycle.
REQ-009 io_fetch_resp_valid / io_fetch_resp_data / io_fetch_resp_err  output  1/XLEN/1  fetch response.
REQ-010 io_dbg_req_valid / io_dbg_req_ready  input/output  1/1  debug/loader handshake.
REQ-011 io_dbg_req_addr / io_dbg_req_wr / io_dbg_req_wdata  input  XLEN/1/XLEN  debug byte address, write flag, write data.
REQ-012 io_dbg_resp_valid / io_dbg_resp_data / io_dbg_resp_err  output  1/XLEN/1  debug response.
REQ-013 io_mem_addr  output  IMEM_DEPTH_LOG2  memory word index.
REQ-014 io_mem_rdata  input  XLEN  combinational read data for io_mem_addr.
REQ-015 io_mem_wen / io_mem_wdata  output  1/XLEN  memory write strobe and data.

Function
REQ-016 A request SHALL be accepted in cycle N iff valid and ready are both high in N; ready SHALL be combinational from valid and arbitration state.
REQ-017 At most one port SHALL be granted per cycle; a sole valid requester SHALL be granted immediately.
REQ-018 When both ports are valid, the grant SHALL go to the port not granted most recently (round-robin); after reset the last-granted pointer SHALL be debug, so fetch wins the first conflict.
REQ-019 The last-granted pointer SHALL update only on an accepted request.
REQ-020 Word index SHALL be addr[IMEM_DEPTH_LOG2+1:2]; io_mem_addr SHALL carry the granted port's index, else 0.
REQ-021 A request with addr[1:0] != 0 or any bit at or above IMEM_DEPTH_LOG2+2 set SHALL be an error: no memory write, response err=1, data=0.
REQ-022 io_mem_wen SHALL equal 1 only in the accept cycle of a legal debug request with wr=1; fetch SHALL never write.
REQ-023 Read data SHALL be captured from io_mem_rdata at the end of the accept cycle; resp_valid SHALL be high in cycle N+1 for exactly one cycle (latency 1, throughput 1/cycle/arbiter).
REQ-024 A debug write response SHALL have data=0, err per REQ-021.
REQ-025 Responses have no backpressure; requesters SHALL always accept them.
REQ-026 io_fetch_flush high in cycle N SHALL force io_fetch_resp_valid low in N; a fetch request accepted in N SHALL still respond in N+1.
REQ-027 Response data and err SHALL be 0 whenever the corresponding resp_valid is 0.

Reset
REQ-028 reset_n low SHALL immediately force all resp_valid, resp_data, resp_err, io_mem_wen low, and the pointer to debug.
REQ-029 A response pending at reset assertion SHALL be dropped; ready outputs SHALL be 0 while reset_n is low.

Structure
REQ-030 Package imem_pkg SHALL hold IMEM_DEPTH_LOG2, XLEN defaults and the port-id enum {PORT_FETCH, PORT_DBG}.
REQ-031 One sub-module rr_arb2 (two-input round-robin arbiter with pointer register) SHALL be instantiated; address checking and response registers stay in imem_arbiter.

Verification
REQ-032 Fetch only, addr 0x10, mem[4]=0xDEADBEEF -> ready in N, resp_valid N+1 data 0xDEADBEEF err 0.
REQ-033 Both valid continuously after reset -> grants alternate fetch, dbg, fetch, dbg; one response per cycle to the matching port.
REQ-034 Dbg write addr 0x8 data 0x12345678 -> io_mem_wen=1, io_mem_addr=2 in N; dbg resp N+1 data 0 err 0; later fetch 0x8 returns 0x12345678.
REQ-035 Fetch addr 0x6 and addr 0x1000 -> no memory access effects, resp err 1, data 0.
REQ-036 Fetch accepted N, flush in N+1 with new fetch accepted -> no resp in N+1, resp in N+2 for the second fetch.
REQ-037 reset_n low in N+1 after accept in N -> resp_valid stays 0; first conflict after release grants fetch.
